// File: rtl/data_mem_if.sv
// Load/store port between the MEM-stage initiator and the data memory responder.
// The initiator drives requests and takes responses; the responder answers one at a time.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding RV32I data memory with programmable wait states, byte/half/word
// access with sign/zero extension, and error reporting for bad size/alignment/range.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept, access;

  logic        wr_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [2:0]  f3_p0;

  logic        vld_p1;
  logic [31:0] rdata_p1;
  logic        err_p1;

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           rd_word;
  logic                  acc_err;

  function automatic logic check_err(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic e;
    e = ((a >> (ADDR_WIDTH + 2)) != 32'd0);
    if (wr) e = e | (f3 > 3'd2);
    else    e = e | (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7);
    if (f3[1:0] == 2'd1) e = e | a[0];
    if (f3[1:0] == 2'd2) e = e | (a[1:0] != 2'd0);
    return e;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ln,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        sh;
    sh = w >> {ln, 3'b000};
    b  = sh[7:0];
    h  = ln[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return 32'(b);
      3'd1:    return 32'(h);
      3'd2:    return w;
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] ln,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] rep;
    logic [31:0] res;
    case (f3[1:0])
      2'd0:    begin be = 4'b0001 << ln;                     rep = {4{d[7:0]}};  end
      2'd1:    begin be = ln[1] ? 4'b1100 : 4'b0011;         rep = {2{d[15:0]}}; end
      default: begin be = 4'b1111;                           rep = d;            end
    endcase
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? rep[8*i +: 8] : w[8*i +: 8];
    return res;
  endfunction

  assign idx     = addr_p0[ADDR_WIDTH+1:2];
  assign lane    = addr_p0[1:0];
  assign rd_word = mem[idx];
  assign acc_err = check_err(wr_p0, f3_p0, addr_p0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        cnt_d   = 4'(LATENCY);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) begin
        access  = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      vld_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        vld_p1   <= 1'b1;
        err_p1   <= acc_err;
        rdata_p1 <= (acc_err || wr_p0) ? 32'd0 : load_ext(f3_p0, lane, rd_word);
      end else if (state_q == RESP && bus.rsp_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Request capture stage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= bus.req_write;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      f3_p0    <= bus.req_funct3;
    end
  end

  // Access stage: reset abandons an in-flight store.
  always_ff @(posedge clk) begin
    if (reset && access && wr_p0 && !acc_err)
      mem[idx] <= store_merge(f3_p0, lane, rd_word, wdata_p0);
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_rdata = rdata_p1;
  assign bus.rsp_err   = err_p1;

endmodule
